// File: rtl/softmax_lut_pkg.sv
// Shared definitions for the softmax LUT loader: default widths, entries-per-word
// helpers and the loader FSM state type.
package softmax_lut_pkg;

  localparam int GBUS_DATA_DEF = 64;
  localparam int LUT_DATA_DEF  = 16;
  localparam int LUT_ADDR_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of LUT entries packed into one bus word.
  function automatic int calc_epw(input int gbus_w, input int lut_w);
    return gbus_w / lut_w;
  endfunction

  // Width needed to hold a valid-slot count 0..epw.
  function automatic int calc_cnt_w(input int epw);
    return $clog2(epw + 1);
  endfunction

  // Width of a slot index 0..epw-1 (at least one bit).
  function automatic int calc_slot_w(input int epw);
    return (epw > 1) ? $clog2(epw) : 1;
  endfunction

endpackage

// File: rtl/softmax_lut_unpacker.sv
// One-word buffer that hands out LUT entries one slot per pop, low slot first.
// Only the first 'count' slots of a loaded word are presented; the rest are dropped.
module softmax_lut_unpacker
  import softmax_lut_pkg::*;
#(
  parameter int GBUS_DATA = GBUS_DATA_DEF,
  parameter int LUT_DATA  = LUT_DATA_DEF
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 flush,
  input  logic                                                 load,
  input  logic [GBUS_DATA-1:0]                                 word,
  input  logic [calc_cnt_w(calc_epw(GBUS_DATA, LUT_DATA))-1:0] count,
  input  logic                                                 pop,
  output logic                                                 valid,
  output logic                                                 last,
  output logic [LUT_DATA-1:0]                                  entry
);

  localparam int EPW = calc_epw(GBUS_DATA, LUT_DATA);
  localparam int NW  = calc_cnt_w(EPW);
  localparam int SW  = calc_slot_w(EPW);

  logic [GBUS_DATA-1:0] word_r;
  logic [SW-1:0]        slot_r;
  logic [NW-1:0]        nvalid_r;
  logic                 valid_r;

  // Buffer state: flush drops the word, load replaces it (even while the old
  // word's last slot is popped), pop advances the slot or empties the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_r   <= {GBUS_DATA{1'b0}};
      slot_r   <= {SW{1'b0}};
      nvalid_r <= {NW{1'b0}};
      valid_r  <= 1'b0;
    end else if (flush) begin
      word_r   <= {GBUS_DATA{1'b0}};
      slot_r   <= {SW{1'b0}};
      nvalid_r <= {NW{1'b0}};
      valid_r  <= 1'b0;
    end else if (load) begin
      word_r   <= word;
      slot_r   <= {SW{1'b0}};
      nvalid_r <= count;
      valid_r  <= 1'b1;
    end else if (pop) begin
      if (last) begin
        slot_r  <= {SW{1'b0}};
        valid_r <= 1'b0;
      end else begin
        slot_r  <= slot_r + SW'(1'b1);
      end
    end
  end

  // Current slot decode: data, and whether it is the last slot worth writing.
  always_comb begin
    valid = valid_r;
    last  = valid_r && (NW'(slot_r) == (nvalid_r - NW'(1'b1)));
    entry = word_r[slot_r*LUT_DATA +: LUT_DATA];
  end

endmodule

// File: rtl/softmax_lut_loader.sv
// Softmax/consmax LUT writer: takes packed entries over valid/ready and issues one
// registered LUT write per cycle at consecutive (wrapping) addresses from a base.
// Optional feature macro: SOFTMAX_LUT_LOADER_CSUM_EN adds a running checksum output
// 'csum' of every written entry.
module softmax_lut_loader
  import softmax_lut_pkg::*;
#(
  parameter int GBUS_DATA = GBUS_DATA_DEF,
  parameter int LUT_DATA  = LUT_DATA_DEF,
  parameter int LUT_ADDR  = LUT_ADDR_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [LUT_ADDR-1:0]  cfg_base_addr,
  input  logic [LUT_ADDR:0]    cfg_count,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  input  logic [GBUS_DATA-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [LUT_ADDR-1:0]  lut_waddr,
  output logic                 lut_wen,
  output logic [LUT_DATA-1:0]  lut_wdata
`ifdef SOFTMAX_LUT_LOADER_CSUM_EN
  ,
  output logic [LUT_DATA-1:0]  csum
`endif
);

  localparam int EPW = calc_epw(GBUS_DATA, LUT_DATA);
  localparam int NW  = calc_cnt_w(EPW);
  localparam int CW  = LUT_ADDR + 1;

  state_t              state;
  state_t              next_state;
  logic [LUT_ADDR-1:0] addr;
  logic [CW-1:0]       remain;     // entries not yet written
  logic [CW-1:0]       load_left;  // entries not yet pulled in from the bus
  logic [NW-1:0]       take;       // valid slots in the word being accepted
  logic                start_acc;
  logic                word_acc;
  logic                emit;
  logic                buf_valid;
  logic                buf_last;
  logic [LUT_DATA-1:0] buf_entry;

  softmax_lut_unpacker #(
    .GBUS_DATA (GBUS_DATA),
    .LUT_DATA  (LUT_DATA)
  ) u_unpacker (
    .clk   (clk),
    .rst   (rst),
    .flush (abort),
    .load  (word_acc),
    .word  (in_data),
    .count (take),
    .pop   (emit),
    .valid (buf_valid),
    .last  (buf_last),
    .entry (buf_entry)
  );

  // Control strobes; abort beats start and suppresses any write in its cycle.
  always_comb begin
    start_acc = (state == IDLE) && start && !abort;
    emit      = (state == LOAD) && buf_valid && !abort;
    word_acc  = in_valid && in_ready;
    if (load_left < CW'(EPW)) begin
      take = NW'(load_left);
    end else begin
      take = NW'(EPW);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state: zero-length loads go straight to DONE; LOAD ends once all entries are out.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start_acc) begin
          next_state = (cfg_count == {CW{1'b0}}) ? DONE : LOAD;
        end else begin
          next_state = IDLE;
        end
      end
      LOAD: begin
        if (abort) begin
          next_state = IDLE;
        end else if (remain == {CW{1'b0}}) begin
          next_state = DONE;
        end else begin
          next_state = LOAD;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs: ready when the buffer is empty or is handing out its last slot
  // while more entries are still owed, so a steady stream has no bubbles.
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    in_ready = 1'b0;
    case (state)
      IDLE: begin
        busy     = 1'b0;
      end
      LOAD: begin
        busy     = 1'b1;
        in_ready = !abort && (load_left != {CW{1'b0}}) && (!buf_valid || buf_last);
      end
      DONE: begin
        done     = 1'b1;
      end
      default: begin
        busy     = 1'b0;
      end
    endcase
  end

  // Address and entry counters: loaded on start, cleared on abort, held across stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr      <= {LUT_ADDR{1'b0}};
      remain    <= {CW{1'b0}};
      load_left <= {CW{1'b0}};
    end else if (start_acc) begin
      addr      <= cfg_base_addr;
      remain    <= cfg_count;
      load_left <= cfg_count;
    end else if (abort) begin
      remain    <= {CW{1'b0}};
      load_left <= {CW{1'b0}};
    end else begin
      if (emit) begin
        addr   <= addr + LUT_ADDR'(1'b1);
        remain <= remain - CW'(1'b1);
      end
      if (word_acc) begin
        load_left <= load_left - CW'(take);
      end
    end
  end

  // LUT write port registers; address/data keep the last written values when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lut_wen   <= 1'b0;
      lut_waddr <= {LUT_ADDR{1'b0}};
      lut_wdata <= {LUT_DATA{1'b0}};
    end else begin
      lut_wen <= emit;
      if (emit) begin
        lut_waddr <= addr;
        lut_wdata <= buf_entry;
      end
    end
  end

`ifdef SOFTMAX_LUT_LOADER_CSUM_EN
  // Running checksum of written entries, restarted by each accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum <= {LUT_DATA{1'b0}};
    end else if (start_acc) begin
      csum <= {LUT_DATA{1'b0}};
    end else if (emit) begin
      csum <= csum + buf_entry;
    end
  end
`endif

endmodule

// File: tb/tb_softmax_lut_loader.sv
// Directed, table-driven bench for softmax_lut_loader (default 64/16/16 widths).
module tb_softmax_lut_loader;

  logic        clk;
  logic        rst;
  logic [15:0] cfg_base_addr;
  logic [16:0] cfg_count;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] lut_waddr;
  logic        lut_wen;
  logic [15:0] lut_wdata;
`ifdef SOFTMAX_LUT_LOADER_CSUM_EN
  logic [15:0] csum;
`endif

  int errors = 0;
  int checks = 0;

  softmax_lut_loader dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_base_addr (cfg_base_addr),
    .cfg_count     (cfg_count),
    .start         (start),
    .abort         (abort),
    .busy          (busy),
    .done          (done),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .lut_waddr     (lut_waddr),
    .lut_wen       (lut_wen),
    .lut_wdata     (lut_wdata)
`ifdef SOFTMAX_LUT_LOADER_CSUM_EN
    ,
    .csum          (csum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]       base;
    logic [16:0]       count;
    int                nwords;
    logic [63:0]       w0;
    logic [63:0]       w1;
    int                gap;
    int                exp_n;
    logic [7:0][15:0]  exp_addr;
    logic [7:0][15:0]  exp_data;
    int                exp_first_t;
    int                exp_done_t;
    int                exp_xfers;
    int                exp_ready;
  } load_vec_t;

  load_vec_t vecs [5];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one load; called #1 after a rising edge with all inputs idle.
  task automatic run_load(input int id, input load_vec_t v);
    int          n;
    int          first_t;
    int          done_t;
    int          xfers;
    int          ready_cnt;
    int          wi;
    int          stall;
    logic        pending;
    logic        busy_at_done;
    logic [15:0] got_addr [8];
    logic [15:0] got_data [8];
    logic [15:0] sum;
    n = 0; first_t = -1; done_t = -1; xfers = 0; ready_cnt = 0;
    wi = 0; stall = 0; busy_at_done = 1'b1; sum = 16'h0000;
    cfg_base_addr = v.base;
    cfg_count     = v.count;
    start         = 1'b1;
    tick();
    start = 1'b0;
    check($sformatf("v%0d busy_t0", id), {63'd0, busy}, {63'd0, (v.count != 17'd0)});
    for (int t = 0; t < 40 && done_t < 0; t++) begin
      if (lut_wen) begin
        if (n < 8) begin
          got_addr[n] = lut_waddr;
          got_data[n] = lut_wdata;
        end
        if (first_t < 0) first_t = t;
        n++;
      end
      if (in_ready) ready_cnt++;
      if (done) begin
        done_t       = t;
        busy_at_done = busy;
      end else begin
        if (wi < v.nwords && stall == 0) begin
          in_valid = 1'b1;
          in_data  = (wi == 0) ? v.w0 : v.w1;
        end else begin
          in_valid = 1'b0;
          if (stall > 0) stall--;
        end
        pending = in_valid && in_ready;
        tick();
        if (pending) begin
          wi++;
          xfers++;
          if (wi == 1) stall = v.gap;
        end
      end
    end
    in_valid = 1'b0;
    check($sformatf("v%0d done_t", id), done_t, v.exp_done_t);
    check($sformatf("v%0d n_writes", id), n, v.exp_n);
    check($sformatf("v%0d xfers", id), xfers, v.exp_xfers);
    check($sformatf("v%0d ready_cycles", id), ready_cnt, v.exp_ready);
    check($sformatf("v%0d busy_at_done", id), {63'd0, busy_at_done}, 64'd0);
    if (v.exp_n > 0) check($sformatf("v%0d first_t", id), first_t, v.exp_first_t);
    for (int k = 0; k < 8; k++) begin
      if (k < v.exp_n) begin
        check($sformatf("v%0d addr%0d", id, k), got_addr[k], v.exp_addr[k]);
        check($sformatf("v%0d data%0d", id, k), got_data[k], v.exp_data[k]);
        sum = sum + v.exp_data[k];
      end
    end
    tick();
    check($sformatf("v%0d done_pulse", id), {63'd0, done}, 64'd0);
    check($sformatf("v%0d wen_after", id), {63'd0, lut_wen}, 64'd0);
`ifdef SOFTMAX_LUT_LOADER_CSUM_EN
    check($sformatf("v%0d csum", id), csum, sum);
`endif
  endtask

  initial begin
    vecs[0] = '{16'h0000, 17'd4, 1, 64'h4444_3333_2222_1111, 64'h0, 0, 4,
                {16'h0, 16'h0, 16'h0, 16'h0, 16'h0003, 16'h0002, 16'h0001, 16'h0000},
                {16'h0, 16'h0, 16'h0, 16'h0, 16'h4444, 16'h3333, 16'h2222, 16'h1111},
                2, 6, 1, 1};
    vecs[1] = '{16'h0010, 17'd8, 2, 64'h4444_3333_2222_1111, 64'h8888_7777_6666_5555, 0, 8,
                {16'h0017, 16'h0016, 16'h0015, 16'h0014, 16'h0013, 16'h0012, 16'h0011, 16'h0010},
                {16'h8888, 16'h7777, 16'h6666, 16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111},
                2, 10, 2, 2};
    vecs[2] = '{16'h0000, 17'd6, 2, 64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005, 5, 6,
                {16'h0, 16'h0, 16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001, 16'h0000},
                {16'h0, 16'h0, 16'h0006, 16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001},
                2, 10, 2, 4};
    vecs[3] = '{16'hFFFE, 17'd4, 1, 64'hDDDD_CCCC_BBBB_AAAA, 64'h0, 0, 4,
                {16'h0, 16'h0, 16'h0, 16'h0, 16'h0001, 16'h0000, 16'hFFFF, 16'hFFFE},
                {16'h0, 16'h0, 16'h0, 16'h0, 16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA},
                2, 6, 1, 1};
    vecs[4] = '{16'h1234, 17'd0, 0, 64'h0, 64'h0, 0, 0, 128'h0, 128'h0, 0, 0, 0, 0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 64'h0;
    cfg_base_addr = 16'h0; cfg_count = 17'd0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    check("reset in_ready", {63'd0, in_ready}, 64'd0);
    check("reset lut_wen", {63'd0, lut_wen}, 64'd0);
    check("reset lut_waddr", lut_waddr, 64'd0);
    check("reset lut_wdata", lut_wdata, 64'd0);
`ifdef SOFTMAX_LUT_LOADER_CSUM_EN
    check("reset csum", csum, 64'd0);
`endif

    for (int i = 0; i < 5; i++) begin
      run_load(i, vecs[i]);
    end

    // Abort after two writes, with start raised in the same cycle.
    cfg_base_addr = 16'h0000; cfg_count = 17'd8; start = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b1; in_data = 64'h4444_3333_2222_1111;
    tick();
    in_valid = 1'b0;
    tick();
    check("abort wr1 wen", {63'd0, lut_wen}, 64'd1);
    check("abort wr1 addr", lut_waddr, 64'h0000);
    tick();
    check("abort wr2 wen", {63'd0, lut_wen}, 64'd1);
    check("abort wr2 data", lut_wdata, 64'h2222);
    abort = 1'b1; start = 1'b1; cfg_base_addr = 16'h5000; cfg_count = 17'd4;
    tick();
    abort = 1'b0; start = 1'b0;
    check("abort wen", {63'd0, lut_wen}, 64'd0);
    check("abort busy", {63'd0, busy}, 64'd0);
    check("abort in_ready", {63'd0, in_ready}, 64'd0);
    check("abort done", {63'd0, done}, 64'd0);
    check("abort hold addr", lut_waddr, 64'h0001);
    check("abort hold data", lut_wdata, 64'h2222);
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("post-abort%0d done", c), {63'd0, done}, 64'd0);
      check($sformatf("post-abort%0d busy", c), {63'd0, busy}, 64'd0);
      check($sformatf("post-abort%0d wen", c), {63'd0, lut_wen}, 64'd0);
    end

    // Asynchronous reset in the middle of a load.
    cfg_base_addr = 16'h0100; cfg_count = 17'd4; start = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b1; in_data = 64'h4444_3333_2222_1111;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("pre-rst wen", {63'd0, lut_wen}, 64'd1);
    check("pre-rst addr", lut_waddr, 64'h0101);
    rst = 1'b1;
    #1;
    check("rst wen", {63'd0, lut_wen}, 64'd0);
    check("rst busy", {63'd0, busy}, 64'd0);
    check("rst in_ready", {63'd0, in_ready}, 64'd0);
    check("rst addr", lut_waddr, 64'd0);
    check("rst data", lut_wdata, 64'd0);
`ifdef SOFTMAX_LUT_LOADER_CSUM_EN
    check("rst csum", csum, 64'd0);
`endif
    tick();
    rst = 1'b0;
    tick();
    run_load(10, vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
